// File: rtl/ga23_sdr_arbiter_if.sv
// Requester, SDRAM and debug signals of the GA23 SDRAM read arbiter.
// The arbiter takes the slave side; the requesters and SDRAM controller take the master side.
interface ga23_sdr_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 22,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ-1:0]    rdy;
    logic [DW-1:0]         rd_data;
    logic                  mem_req;
    logic [AW-1:0]         mem_addr;
    logic                  mem_ack;
    logic [DW-1:0]         mem_data;
    logic                  overrun;
    logic [7:0]            overrun_cnt;

    modport slave (
        input  req, req_addr, mem_ack, mem_data,
        output rdy, rd_data, mem_req, mem_addr, overrun, overrun_cnt
    );

    modport master (
        output req, req_addr, mem_ack, mem_data,
        input  rdy, rd_data, mem_req, mem_addr, overrun, overrun_cnt
    );
endinterface

// File: rtl/ga23_sdr_arbiter.sv
// Round-robin SDRAM row-fetch arbiter, one pending fetch per requester; req -> mem_req in 2 clks, ack -> rdy in 1 clk.
// No backpressure to requesters: a newer request replaces the pending or in-flight one and pulses overrun.
module ga23_sdr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 22,
    parameter int DW      = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    ga23_sdr_arbiter_if.slave        bus
);
    localparam int RW = $clog2(NUM_REQ);
    localparam logic [RW:0]   NREQ_W = (RW+1)'(NUM_REQ);
    localparam logic [RW-1:0] LAST   = RW'(NUM_REQ - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                     state_q, state_d;
    logic [NUM_REQ-1:0]         pend_q, pend_d;
    logic [NUM_REQ-1:0]         stale_q, stale_d;
    logic [NUM_REQ-1:0]         rdy_q, rdy_d;
    logic [NUM_REQ-1:0][AW-1:0] paddr_q, paddr_d;
    logic [RW-1:0]              rr_q, rr_d;
    logic [RW-1:0]              cur_q, cur_d;
    logic                       mem_req_q, mem_req_d;
    logic [AW-1:0]              mem_addr_q, mem_addr_d;
    logic [DW-1:0]              rd_data_q, rd_data_d;
    logic                       overrun_q, overrun_d;
    logic [7:0]                 overrun_cnt_q, overrun_cnt_d;

    logic [RW-1:0]              sel;
    logic                       sel_vld;
    logic [RW:0]                sum;
    logic                       ovr;

    // First pending requester at or after the round-robin pointer.
    always_comb begin
        sel     = rr_q;
        sel_vld = 1'b0;
        sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_q} + (RW+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            if (!sel_vld && pend_q[sum[RW-1:0]]) begin
                sel     = sum[RW-1:0];
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        paddr_d    = paddr_q;
        stale_d    = stale_q;
        rr_d       = rr_q;
        cur_d      = cur_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        rd_data_d  = rd_data_q;
        rdy_d      = '0;
        ovr        = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d     = BUSY;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = paddr_q[sel];
                    pend_d[sel] = 1'b0;
                    cur_d       = sel;
                    rr_d        = (sel == LAST) ? '0 : sel + RW'(1);
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    state_d        = IDLE;
                    mem_req_d      = 1'b0;
                    rdy_d[cur_q]   = ~stale_q[cur_q];
                    stale_d[cur_q] = 1'b0;
                    if (!stale_q[cur_q]) begin
                        rd_data_d = bus.mem_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // New requests land after the grant so a same-cycle grant issues the old address.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i]) begin
                if (pend_q[i]) begin
                    ovr = 1'b1;
                end
                if (state_q == BUSY && cur_q == RW'(i) && !bus.mem_ack) begin
                    stale_d[i] = 1'b1;
                    ovr        = 1'b1;
                end
                pend_d[i]  = 1'b1;
                paddr_d[i] = bus.req_addr[i*AW +: AW];
            end
        end

        overrun_d     = ovr;
        overrun_cnt_d = (ovr && overrun_cnt_q != 8'hFF) ? overrun_cnt_q + 8'd1 : overrun_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pend_q        <= '0;
            paddr_q       <= '0;
            stale_q       <= '0;
            rr_q          <= '0;
            cur_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            rd_data_q     <= '0;
            rdy_q         <= '0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            paddr_q       <= paddr_d;
            stale_q       <= stale_d;
            rr_q          <= rr_d;
            cur_q         <= cur_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            rd_data_q     <= rd_data_d;
            rdy_q         <= rdy_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign bus.rdy         = rdy_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.overrun     = overrun_q;
    assign bus.overrun_cnt = overrun_cnt_q;
endmodule
